// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: IF -> ID -> EX -> (MEM) -> WB with
// handshake stalls, a HALT stop state and a saturating retired-instruction count.
module stage_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             imem_rdy,
   input  logic             is_halt,
   input  logic             is_mem,
   input  logic             dmem_ack,
   output logic [4:0]       stat,
   output logic             dmem_req,
   output logic             pc_we,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] retire_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_IF,
      S_ID,
      S_EX,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t state;
   state_t state_nx;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [4:0] stat_of(input state_t s);
      case (s)
         S_IF:    stat_of = 5'b00001;
         S_ID:    stat_of = 5'b00010;
         S_EX:    stat_of = 5'b00100;
         S_MEM:   stat_of = 5'b01000;
         S_WB:    stat_of = 5'b10000;
         default: stat_of = 5'b00000;
      endcase
   endfunction

   // Each handshake input is only looked at in the one state that owns it.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start)    state_nx = S_IF;
         S_IF:    if (imem_rdy) state_nx = S_ID;
         S_ID:    state_nx = is_halt ? S_HALT : S_EX;
         S_EX:    state_nx = is_mem ? S_MEM : S_WB;
         S_MEM:   if (dmem_ack) state_nx = S_WB;
         S_WB:    state_nx = S_IF;
         S_HALT:  if (start)    state_nx = S_IF;
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         stat       <= 5'b00000;
         dmem_req   <= 1'b0;
         pc_we      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         retire_cnt <= '0;
      end else begin
         state    <= state_nx;
         stat     <= stat_of(state_nx);
         dmem_req <= (state_nx == S_MEM);
         pc_we    <= (state_nx == S_WB);
         busy     <= (state_nx != S_IDLE) && (state_nx != S_HALT);
         done     <= (state_nx == S_HALT);
         if ((state == S_IDLE || state == S_HALT) && start)
            retire_cnt <= '0;
         else if (state == S_WB && retire_cnt != {CNT_W{1'b1}})
            retire_cnt <= retire_cnt + CNT_ONE;
      end
   end

endmodule
